// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, register indices, flag bits and fetch-state encoding.
package cpu_pkg;

   localparam int CPU_ADDR_W = 16;
   localparam int CPU_DATA_W = 16;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4;
   localparam logic [4:0] OP_NOT = 5'd5;
   localparam logic [4:0] OP_SHL = 5'd6;
   localparam logic [4:0] OP_SHR = 5'd7;
   localparam logic [4:0] OP_MOV = 5'd8;
   localparam logic [4:0] OP_LDI = 5'd9;
   localparam logic [4:0] OP_CMP = 5'd10;
   localparam logic [4:0] OP_BRI = 5'd11;
   localparam logic [4:0] OP_BRZ = 5'd12;
   localparam logic [4:0] OP_BRN = 5'd13;
   localparam logic [4:0] OP_STW = 5'd14;
   localparam logic [4:0] OP_LDW = 5'd15;

   // 0-7 are general purpose registers
   localparam logic [3:0] REG_R0 = 4'd0;
   localparam logic [3:0] REG_R7 = 4'd7;
   localparam logic [3:0] REG_PC = 4'd8;
   localparam logic [3:0] REG_IR = 4'd9;
   localparam logic [3:0] REG_FR = 4'd10;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} with flush; push visible on the next cycle, no bypass.
// Pop is ignored when empty or flushing; flush wins over push/pop on the same edge.
module fetch_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_instr,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              pop,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_instr,
   output logic [ADDR_W-1:0] head_pc,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [ADDR_W-1:0] mem_pc    [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [DATA_W-1:0] hold_instr;
   logic [ADDR_W-1:0] hold_pc;
   logic              pop_eff;

   assign head_valid = (count != '0);
   assign pop_eff    = pop && head_valid;
   // When empty, keep showing the last head rather than a stale slot
   assign head_instr = head_valid ? mem_instr[rd_ptr] : hold_instr;
   assign head_pc    = head_valid ? mem_pc[rd_ptr]    : hold_pc;

   always_ff @(posedge clk) begin
      if (reset && push && !flush) begin
         mem_instr[wr_ptr] <= push_instr;
         mem_pc[wr_ptr]    <= push_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         hold_instr <= '0;
         hold_pc    <= '0;
      end else begin
         if (head_valid) begin
            hold_instr <= mem_instr[rd_ptr];
            hold_pc    <= mem_pc[rd_ptr];
         end
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff)
               rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop_eff);
         end
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
      !(push && !flush && (count == DEPTH_C)));

endmodule

// File: rtl/cpu_fetch_unit.sv
// Fetch stage: one outstanding imem read, prefetch FIFO to the core; ack->instr_valid 1 cycle.
// Stops fetching when the FIFO (counting the in-flight slot) is full; redirect flushes and drops in-flight data.
module cpu_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W     = CPU_ADDR_W,
   parameter int                DATA_W     = CPU_DATA_W,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              CLK,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] fetch_pc_nxt;
   logic [ADDR_W-1:0] disc_addr;
   logic              push;
   logic              pop;
   logic              flush;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_after;

   assign pop         = instr_valid && instr_ready;
   assign count_after = count + CNT_W'(1) - CNT_W'(pop);
   assign imem_req    = (state == ST_FETCH) || (state == ST_DISCARD);
   // A discarded read must keep its original address until acked
   assign imem_addr   = (state == ST_DISCARD) ? disc_addr : fetch_pc;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      push         = 1'b0;
      flush        = 1'b0;
      if (redirect_valid) begin
         flush        = 1'b1;
         fetch_pc_nxt = redirect_pc;
         case (state)
            ST_FETCH:   state_nxt = imem_ack ? ST_FETCH : ST_DISCARD;
            ST_DISCARD: state_nxt = imem_ack ? ST_FETCH : ST_DISCARD;
            default:    state_nxt = ST_FETCH;
         endcase
      end else begin
         case (state)
            ST_IDLE: begin
               if (count < DEPTH_C)
                  state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  push         = 1'b1;
                  fetch_pc_nxt = fetch_pc + ADDR_W'(1);
                  state_nxt    = (count_after < DEPTH_C) ? ST_FETCH : ST_IDLE;
               end
            end
            ST_DISCARD: begin
               if (imem_ack)
                  state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state     <= ST_IDLE;
         fetch_pc  <= RESET_PC;
         disc_addr <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (state != ST_DISCARD)
            disc_addr <= fetch_pc;
      end
   end

   fetch_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk        (CLK),
      .reset      (reset),
      .flush      (flush),
      .push       (push),
      .push_instr (imem_rdata),
      .push_pc    (fetch_pc),
      .pop        (pop),
      .head_valid (instr_valid),
      .head_instr (instr),
      .head_pc    (instr_pc),
      .count      (count)
   );

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
Instruction fetch stage directly upstream of the cpu core. Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Buffers returned 16-bit instructions with their PCs in a small prefetch FIFO and presents them to the core's IR load with valid/ready. Accepts branch redirects from the core: the FIFO is flushed and any in-flight read is discarded.

Parameters:
ADDR_W, 16, fetch address width (word addressed)
DATA_W, 16, instruction width
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)
RESET_PC, 16'h0000, first fetch address after reset

Ports:
CLK  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  read request, held until acked
imem_addr  out  ADDR_W  read address, stable while imem_req high
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  DATA_W  read data
redirect_valid  in  1  core branch taken (OP_BRI), 1-cycle pulse
redirect_pc  in  ADDR_W  branch target
instr_valid  out  1  FIFO head valid
instr  out  DATA_W  FIFO head instruction
instr_pc  out  ADDR_W  address of instr
instr_ready  in  1  core consumes head when instr_valid&&instr_ready

Behaviour:
- Reset (reset==0 at edge): fetch_pc=RESET_PC, FIFO empty, state IDLE. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: no request outstanding.
  - FETCH: imem_req=1, imem_addr=fetch_pc.
  - DISCARD: imem_req=1 at the old address; the returned data is dropped.
- IDLE->FETCH when no redirect and count<FIFO_DEPTH. The pending read owns the reserved slot, so at most one request is outstanding.
- FETCH with imem_ack:
  - Push {imem_rdata, fetch_pc}.
  - fetch_pc+=1, wrapping 16'hFFFF->16'h0000.
  - Go to FETCH if count_after_push<FIFO_DEPTH, else IDLE.
  - Back-to-back fetches are allowed, giving 1 instruction/cycle with zero-wait memory.
- Handshake rule: once imem_req rises, imem_req and imem_addr must not change until the imem_ack cycle. Ack may arrive in the same cycle req rises.
- Redirect has priority over all other events:
  - FIFO is flushed on the same edge, so instr_valid=0 next cycle. A pop in that cycle is ignored.
  - fetch_pc is set to redirect_pc.
  - From FETCH without ack in the same cycle: go to DISCARD. Address stays old.
  - From FETCH with ack in the same cycle: data is dropped and the next state is FETCH at redirect_pc.
  - From IDLE: next state is FETCH at redirect_pc.
  - Redirect while in DISCARD: fetch_pc is updated and the state stays DISCARD.
- DISCARD with imem_ack: data is dropped and the next state is FETCH at fetch_pc.
- Latency:
  - imem_ack to instr_valid: 1 cycle (registered FIFO, no bypass).
  - Reset release to first imem_req: 1 cycle.
  - Redirect to new-target imem_req: 1 cycle, or ack+1 if discarding.
- Simultaneous push and pop: both take effect and count is unchanged. Push into a full FIFO cannot occur by construction; the assertion must flag it.
- instr and instr_pc hold the head entry. When empty they hold their last value; the core ignores them while instr_valid=0.
- reset asserted mid-request: imem_req=0 next cycle. Memory must abandon the transaction.

Decomposition:
- Shared package cpu_pkg:
  - OP_* opcode constants (5-bit, OP_ADD..OP_LDW).
  - Register index constants: 0-7 GPR, 8 PC, 9 IR, 10 FR.
  - FLAG_Z/FLAG_N bit positions.
  - ADDR_W/DATA_W defaults.
  - Fetch state encoding.
- One sub-module, fetch_fifo: synchronous FIFO with flush, push/pop, and count. Each entry is {instr, pc}.

Test Plan:
- Reset low 3 cycles, release; memory with same-cycle ack returning addr^16'hA5A5; instr_ready=1 -> imem_addr 0,1,2,... each cycle; instr_valid from cycle 2 with instr=16'hA5A5, instr_pc=0; then instr_pc=1 with instr=16'hA5A4.
- instr_ready=0 with 0-wait memory -> exactly 2 entries accepted (pc 0,1); imem_req stays 0; raise instr_ready for 1 cycle -> one new request at addr 2.
- Memory with 3-cycle ack latency; redirect_pc=16'h0040 one cycle after req to addr 5 -> req/addr 5 held until ack; data dropped; next req addr 16'h0040; first instr_pc delivered is 16'h0040.
- redirect_valid in the same cycle as imem_ack and instr_valid&&instr_ready with redirect_pc=16'h0100 -> FIFO empty next cycle; ack data never appears; next imem_addr=16'h0100.
- Redirect to 16'hFFFE with 0-wait memory -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Pull reset low while a request is waiting for ack -> imem_req=0 and instr_valid=0 next cycle; after release the first imem_addr is RESET_PC.
